eccop_opxfer: RTL and testbench

- Bus-initiator for the ECCOP operand memory 32-bit slave port: moves whole 260-bit operands between a wide command/response port and the 64-row operand memory.
- A store becomes 8 acknowledged 32-bit lane writes. A load becomes one row read plus 9 word fetches.
- Sits between the host-side command logic and the operand memory bus port. It stalls when the ECC datapath holds write priority, which the slave signals by withholding wready.

---
 rtl/eccop_opxfer.sv | 130 +++++++++++++
 tb/tb_eccop_opxfer.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/eccop_opxfer.sv
// ECCOP operand transfer initiator: moves 260-bit operands between a wide command port
// and the 64-row operand memory's 32-bit slave port (8 lane writes, or 1 row read + 9 fetches).
module eccop_opxfer #(
   parameter int WAIT_MAX = 255
) (
   input  logic         clk,
   input  logic         arst,
   input  logic         cmd_valid,
   output logic         cmd_ready,
   input  logic         cmd_wr,
   input  logic [5:0]   cmd_row,
   input  logic [259:0] cmd_wdata,
   output logic         rsp_valid,
   output logic         rsp_err,
   output logic [259:0] rsp_rdata,
   output logic [9:0]   bus_addr,
   output logic [31:0]  bus_wdata,
   output logic         bus_write,
   output logic         bus_read,
   input  logic [31:0]  bus_rdata,
   input  logic         bus_wready
);
   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_WR_LANE = 3'd1;
   localparam logic [2:0] S_RD_ROW  = 3'd2;
   localparam logic [2:0] S_RD_WORD = 3'd3;
   localparam logic [2:0] S_DONE    = 3'd4;

   // The wait counter only ever holds 0..WAIT_MAX-1; reaching the top value aborts.
   localparam int WW = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX);

   logic [2:0]    state_q, state_d;
   logic [5:0]    row_q, row_d;
   logic [255:0]  wdata_q, wdata_d;
   logic [3:0]    k_q, k_d;
   logic [WW-1:0] wait_q, wait_d;
   logic          err_q, err_d;
   logic [255:0]  buf_q, buf_d;
   logic [259:0]  rdata_q, rdata_d;
   logic [31:0]   lane_w [8];

   generate
      for (genvar gi = 0; gi < 8; gi++) begin : g_lane
         assign lane_w[gi] = wdata_q[32*gi +: 32];
      end
   endgenerate

   always_comb begin
      state_d = state_q;
      row_d   = row_q;
      wdata_d = wdata_q;
      k_d     = k_q;
      wait_d  = wait_q;
      err_d   = err_q;
      buf_d   = buf_q;
      rdata_d = rdata_q;
      case (state_q)
         S_IDLE: begin
            if (cmd_valid) begin
               row_d   = cmd_row;
               wdata_d = cmd_wdata[255:0];
               k_d     = 4'd0;
               wait_d  = '0;
               // The slave port cannot store the top nibble; flag it but still write the lanes.
               err_d   = cmd_wr && (cmd_wdata[259:256] != 4'd0);
               state_d = cmd_wr ? S_WR_LANE : S_RD_ROW;
            end
         end
         S_WR_LANE: begin
            if (bus_wready) begin
               wait_d = '0;
               if (k_q == 4'd7) state_d = S_DONE;
               else             k_d     = k_q + 4'd1;
            end else if (wait_q == WW'(WAIT_MAX - 1)) begin
               err_d   = 1'b1;
               state_d = S_DONE;
            end else begin
               wait_d = wait_q + 1'b1;
            end
         end
         S_RD_ROW: begin
            k_d     = 4'd0;
            state_d = S_RD_WORD;
         end
         S_RD_WORD: begin
            if (k_q[3]) begin
               // Result register only changes once the whole operand is assembled.
               rdata_d = {bus_rdata[3:0], buf_q};
               state_d = S_DONE;
            end else begin
               buf_d[{k_q[2:0], 5'd0} +: 32] = bus_rdata;
               k_d = k_q + 4'd1;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         state_q <= S_IDLE;
         row_q   <= '0;
         wdata_q <= '0;
         k_q     <= '0;
         wait_q  <= '0;
         err_q   <= 1'b0;
         buf_q   <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         row_q   <= row_d;
         wdata_q <= wdata_d;
         k_q     <= k_d;
         wait_q  <= wait_d;
         err_q   <= err_d;
         buf_q   <= buf_d;
         rdata_q <= rdata_d;
      end
   end

   assign cmd_ready = (state_q == S_IDLE) && !arst;
   assign bus_write = (state_q == S_WR_LANE);
   assign bus_read  = (state_q == S_RD_ROW);
   assign bus_addr  = (bus_write || bus_read || state_q == S_RD_WORD) ? {row_q, k_q} : 10'd0;
   assign bus_wdata = bus_write ? lane_w[k_q[2:0]] : 32'd0;
   assign rsp_valid = (state_q == S_DONE);
   assign rsp_err   = rsp_valid && err_q;
   assign rsp_rdata = rdata_q;
endmodule

// File: tb/tb_eccop_opxfer.sv
// Bench for eccop_opxfer: slave-port memory model, operand-level reference memory and
// scoreboard queues for responses, bus writes and row reads.
module tb_eccop_opxfer;
   localparam int WAIT_MAX = 8;

   logic         clk = 1'b0;
   logic         arst = 1'b1;
   logic         cmd_valid = 1'b0, cmd_wr = 1'b0;
   logic [5:0]   cmd_row = '0;
   logic [259:0] cmd_wdata = '0;
   logic         cmd_ready, rsp_valid, rsp_err, bus_write, bus_read;
   logic [259:0] rsp_rdata;
   logic [9:0]   bus_addr;
   logic [31:0]  bus_wdata, bus_rdata;
   logic         bus_wready = 1'b0;

   typedef struct {
      logic         err;
      logic         is_load;
      logic [259:0] rdata;
      int           lat;
      int           acc;
   } rsp_t;
   typedef struct {
      logic [9:0]  addr;
      logic [31:0] data;
      logic        commits;
   } wr_t;

   rsp_t         rsp_q[$];
   wr_t          wr_q[$];
   logic [9:0]   rd_q[$];
   logic [259:0] ref_mem [64];
   logic [259:0] slv_mem [64];
   logic [259:0] latched = '0;
   logic [259:0] last_load = '0;
   int           need [8];
   bit           never_ack = 1'b0;
   int           cyc = 0;
   int           n_checks = 0, n_pass = 0, n_commits = 0;
   int           wait_cnt = 0;
   bit           prev_ack = 1'b0, ack = 1'b0, read_pend = 1'b0;
   logic [5:0]   rd_row = '0;
   rsp_t         mon_r;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   eccop_opxfer #(.WAIT_MAX(WAIT_MAX)) dut (
      .clk(clk), .arst(arst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
      .cmd_row(cmd_row), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
      .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_write(bus_write),
      .bus_read(bus_read), .bus_rdata(bus_rdata), .bus_wready(bus_wready)
   );

   function automatic void check(string name, logic [259:0] act, logic [259:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endfunction

   // Slave read port: whole row latched on bus_read, then words selected by address.
   assign bus_rdata = bus_addr[3] ? {28'd0, latched[259:256]} : latched[{bus_addr[2:0], 5'd0} +: 32];

   always @(posedge clk) if (read_pend) latched = slv_mem[rd_row];

   // Slave write port and bus-side checks, evaluated mid-cycle.
   always @(negedge clk) begin
      if (arst) begin
         wait_cnt = 0; prev_ack = 1'b0; bus_wready = 1'b0; read_pend = 1'b0;
      end else begin
         read_pend = bus_read;
         rd_row    = bus_addr[9:4];
         if (bus_read) begin
            if (rd_q.size() == 0) check("rd_unexpected", 260'(1), 260'(0));
            else check("rd_addr", 260'(bus_addr), 260'(rd_q.pop_front()));
         end
         ack = 1'b0;
         if (bus_write) begin
            wait_cnt++;
            if (wr_q.size() == 0) check("wr_unexpected", 260'(1), 260'(0));
            else begin
               check("wr_addr", 260'(bus_addr), 260'(wr_q[0].addr));
               check("wr_data", 260'(bus_wdata), 260'(wr_q[0].data));
            end
            ack = !never_ack && !prev_ack && (wait_cnt >= need[bus_addr[2:0]]);
         end else begin
            wait_cnt = 0;
         end
         bus_wready = ack;
         if (ack) begin
            if (wr_q.size() != 0) begin
               check("wr_commit_allowed", 260'(wr_q[0].commits), 260'(1));
               void'(wr_q.pop_front());
            end
            slv_mem[bus_addr[9:4]][{bus_addr[2:0], 5'd0} +: 32] = bus_wdata;
            slv_mem[bus_addr[9:4]][259:256] = 4'h0;
            wait_cnt = 0;
            n_commits++;
         end
         prev_ack = ack;
      end
   end

   // Response monitor.
   always @(negedge clk) begin
      if (!arst && rsp_valid) begin
         if (rsp_q.size() == 0) check("rsp_unexpected", 260'(1), 260'(0));
         else begin
            mon_r = rsp_q.pop_front();
            check("rsp_err", 260'(rsp_err), 260'(mon_r.err));
            check("rsp_latency", 260'(cyc - mon_r.acc + 1), 260'(mon_r.lat));
            check(mon_r.is_load ? "rsp_rdata_load" : "rsp_rdata_held", rsp_rdata, mon_r.rdata);
         end
      end
   end

   task automatic issue(input logic wr, input logic [5:0] row, input logic [259:0] data, input bit tmo);
      rsp_t r;
      int   guard, sum;
      @(negedge clk);
      cmd_valid = 1'b1; cmd_wr = wr; cmd_row = row; cmd_wdata = data;
      guard = 0;
      while (!cmd_ready && guard < 50) begin @(negedge clk); guard++; end
      check("cmd_accept", 260'(cmd_ready), 260'(1));
      r.acc = cyc;
      r.is_load = !wr;
      if (wr) begin
         sum = 0;
         for (int k = 0; k < 8; k++) sum += need[k];
         if (tmo) begin
            wr_q.push_back('{addr: {row, 1'b0, 3'd0}, data: data[31:0], commits: 1'b0});
            r.err = 1'b1;
            r.lat = WAIT_MAX + 2;
         end else begin
            for (int k = 0; k < 8; k++)
               wr_q.push_back('{addr: {row, 1'b0, 3'(k)}, data: data[32*k +: 32], commits: 1'b1});
            r.err = (data[259:256] != 4'h0);
            r.lat = 2 + sum;
            ref_mem[row] = {4'h0, data[255:0]};
         end
         r.rdata = last_load;
      end else begin
         rd_q.push_back({row, 4'd0});
         r.err = 1'b0;
         r.lat = 12;
         r.rdata = ref_mem[row];
         last_load = ref_mem[row];
      end
      rsp_q.push_back(r);
      @(posedge clk);
      #1 cmd_valid = 1'b0;
   endtask

   task automatic wait_done(input int left);
      int guard;
      guard = 0;
      while (rsp_q.size() != 0 && guard < 3000) begin @(negedge clk); guard++; end
      check("rsp_arrived", 260'(rsp_q.size()), 260'(0));
      check("wr_left", 260'(wr_q.size()), 260'(left));
      rsp_q.delete(); wr_q.delete(); rd_q.delete();
      @(negedge clk);
   endtask

   logic [259:0] d;
   logic         rwr;
   logic [5:0]   rrow;
   int           base, guard;

   initial begin
      for (int i = 0; i < 64; i++) begin ref_mem[i] = '0; slv_mem[i] = '0; end
      for (int k = 0; k < 8; k++) need[k] = 2;

      // Reset state
      #12;
      check("rst_cmd_ready", 260'(cmd_ready), 260'(0));
      check("rst_rsp_valid", 260'(rsp_valid), 260'(0));
      check("rst_rsp_err", 260'(rsp_err), 260'(0));
      check("rst_rsp_rdata", rsp_rdata, 260'(0));
      check("rst_bus_write", 260'(bus_write), 260'(0));
      check("rst_bus_read", 260'(bus_read), 260'(0));
      check("rst_bus_addr", 260'(bus_addr), 260'(0));
      check("rst_bus_wdata", 260'(bus_wdata), 260'(0));
      @(posedge clk); #2 arst = 1'b0;
      @(negedge clk);
      check("post_rst_cmd_ready", 260'(cmd_ready), 260'(1));

      // Store row 5, lanes 0x11111111*k, then load it back
      d = '0;
      for (int k = 0; k < 8; k++) d[32*k +: 32] = 32'h11111111 * k;
      issue(1'b1, 6'd5, d, 1'b0);
      wait_done(0);
      issue(1'b0, 6'd5, '0, 1'b0);
      wait_done(0);

      // Lane 3 held off for 6 cycles
      for (int k = 0; k < 8; k++) d[32*k +: 32] = $urandom;
      d[259:256] = 4'h0;
      need[3] = 7;
      issue(1'b1, 6'd9, d, 1'b0);
      wait_done(0);
      need[3] = 2;
      issue(1'b0, 6'd9, '0, 1'b0);
      wait_done(0);

      // Write acknowledge never arrives
      never_ack = 1'b1;
      base = n_commits;
      issue(1'b1, 6'd12, {4'h0, {8{32'hDEADBEEF}}}, 1'b1);
      wait_done(1);
      never_ack = 1'b0;
      check("tmo_no_commit", 260'(n_commits - base), 260'(0));
      check("tmo_bus_write_low", 260'(bus_write), 260'(0));
      issue(1'b0, 6'd12, '0, 1'b0);
      wait_done(0);

      // Unsupported top nibble
      for (int k = 0; k < 8; k++) d[32*k +: 32] = $urandom;
      d[259:256] = 4'hA;
      issue(1'b1, 6'd20, d, 1'b0);
      wait_done(0);
      issue(1'b0, 6'd20, '0, 1'b0);
      wait_done(0);

      // Asynchronous reset while lane 4 is on the bus
      for (int k = 0; k < 8; k++) d[32*k +: 32] = $urandom;
      d[259:256] = 4'h0;
      need[4] = 5;
      base = n_commits;
      issue(1'b1, 6'd30, d, 1'b0);
      guard = 0;
      while (n_commits < base + 4 && guard < 200) begin @(negedge clk); guard++; end
      @(negedge clk);
      check("pre_rst_write", 260'(bus_write), 260'(1));
      check("pre_rst_addr", 260'(bus_addr), 260'({6'd30, 4'd4}));
      #2 arst = 1'b1;
      #1;
      check("arst_bus_write", 260'(bus_write), 260'(0));
      check("arst_rsp_valid", 260'(rsp_valid), 260'(0));
      check("arst_bus_addr", 260'(bus_addr), 260'(0));
      check("arst_bus_wdata", 260'(bus_wdata), 260'(0));
      check("arst_cmd_ready", 260'(cmd_ready), 260'(0));
      @(posedge clk); #2 arst = 1'b0;
      @(negedge clk);
      check("arst_release_ready", 260'(cmd_ready), 260'(1));
      check("arst_lanes_done", 260'(n_commits - base), 260'(4));
      rsp_q.delete(); wr_q.delete(); rd_q.delete();
      ref_mem[30] = {4'h0, ref_mem[30][255:128], d[127:0]};
      last_load = '0;
      need[4] = 2;
      issue(1'b0, 6'd5, '0, 1'b0);
      wait_done(0);

      // Randomized mix of stores and loads with random acknowledge delays
      for (int n = 0; n < 40; n++) begin
         for (int w = 0; w < 8; w++) d[32*w +: 32] = $urandom;
         d[259:256] = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
         rwr  = 1'($urandom_range(0, 1));
         rrow = 6'($urandom_range(0, 7));
         for (int k = 0; k < 8; k++) need[k] = 2 + $urandom_range(0, 3);
         issue(rwr, rrow, d, 1'b0);
         if ($urandom_range(0, 2) == 0) begin
            @(negedge clk);
            if (!cmd_ready) begin
               cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_row = 6'd63;
               @(negedge clk);
               cmd_valid = 1'b0;
            end
         end
         wait_done(0);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
